// File: rtl/sound_sequencer_pkg.sv
// Shared clip-select encoding, default clip lengths and sizing helpers for the sound sequencer.
package sound_sequencer_pkg;

  typedef enum logic [2:0] {
    SOUND_LOADING   = 3'd0,
    SOUND_READY     = 3'd1,
    SOUND_WIN       = 3'd2,
    SOUND_GAME_PLAY = 3'd3,
    SOUND_FAIL      = 3'd4
  } sound_t;

  localparam int DEF_CLK_HZ        = 25_000_000;
  localparam int DEF_SAMPLE_HZ     = 8_000;
  localparam int DEF_READY_SAMPLES = 32_000;
  localparam int DEF_CHOMP_SAMPLES = 5_736;
  localparam int DEF_WIN_SAMPLES   = 16_000;
  localparam int DEF_FAIL_SAMPLES  = 12_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sound_sequencer_strobe_gen.sv
// Free-running rate strobe: one registered 1-cycle pulse every DIV clocks, first DIV clocks after reset.
// Latency: strobe registered from the counter wrap; no backpressure, never gated.
module strobe_gen #(
  parameter int DIV = 3125
) (
  input  logic clk_25MHZ,
  input  logic rst_n,
  output logic strobe
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    strobe_d = 1'b0;
    cnt_d    = cnt_q + CW'(1);
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d    = '0;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25MHZ) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/sound_sequencer.sv
// Audio control stage: owns the sample strobe, picks the clip, times clip length and arbitrates game events.
// Latency: every output registered, one cycle after the decision; events are pulses, losers are dropped.
module sound_sequencer
  import sound_sequencer_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int SAMPLE_HZ     = DEF_SAMPLE_HZ,
  parameter int READY_SAMPLES = DEF_READY_SAMPLES,
  parameter int CHOMP_SAMPLES = DEF_CHOMP_SAMPLES,
  parameter int WIN_SAMPLES   = DEF_WIN_SAMPLES,
  parameter int FAIL_SAMPLES  = DEF_FAIL_SAMPLES
) (
  input  logic   clk_25MHZ,
  input  logic   rst_n,
  input  logic   game_loaded,
  input  logic   pellet_eaten,
  input  logic   level_won,
  input  logic   player_died,
  output sound_t sound_type,
  output logic   clk_8KHZ,
  output logic   clip_start,
  output logic   audio_en,
  output logic   busy
);

  localparam int DIV     = CLK_HZ / SAMPLE_HZ;
  localparam int CLIP_W  = cnt_w(max3(READY_SAMPLES, WIN_SAMPLES, FAIL_SAMPLES));
  localparam int CHOMP_W = cnt_w(CHOMP_SAMPLES);

  localparam logic [2:0] ST_LOADING = 3'd0;
  localparam logic [2:0] ST_READY   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_WIN     = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;

  logic strobe;

  strobe_gen #(.DIV(DIV)) u_strobe_gen (
    .clk_25MHZ (clk_25MHZ),
    .rst_n     (rst_n),
    .strobe    (strobe)
  );

  logic [2:0]         state_q, state_d;
  logic [CLIP_W-1:0]  clip_q, clip_d;
  logic [CHOMP_W-1:0] chomp_q, chomp_d;
  sound_t             sound_type_q, sound_type_d;
  logic               clip_start_q, clip_start_d;
  logic               audio_en_q, audio_en_d;
  logic               busy_q, busy_d;
  logic               clip_done;

  assign clip_done = strobe && (clip_q == '0);

  always_comb begin
    state_d      = state_q;
    clip_d       = clip_q;
    chomp_d      = chomp_q;
    clip_start_d = 1'b0;

    if (strobe && (chomp_q != '0)) chomp_d = chomp_q - CHOMP_W'(1);
    if (strobe && (clip_q != '0))  clip_d  = clip_q - CLIP_W'(1);

    // Losing the assets overrides everything, including a coincident clip end or event.
    if (!game_loaded) begin
      state_d = ST_LOADING;
      chomp_d = '0;
      clip_d  = '0;
    end else begin
      case (state_q)
        ST_LOADING: begin
          state_d      = ST_READY;
          clip_d       = CLIP_W'(READY_SAMPLES - 1);
          clip_start_d = 1'b1;
        end
        ST_READY: begin
          if (clip_done) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (player_died) begin
            state_d      = ST_FAIL;
            clip_d       = CLIP_W'(FAIL_SAMPLES - 1);
            chomp_d      = '0;
            clip_start_d = 1'b1;
          end else if (level_won) begin
            state_d      = ST_WIN;
            clip_d       = CLIP_W'(WIN_SAMPLES - 1);
            chomp_d      = '0;
            clip_start_d = 1'b1;
          end else if (pellet_eaten) begin
            // A retrigger only extends the chomp; the player keeps its sample address.
            chomp_d      = CHOMP_W'(CHOMP_SAMPLES);
            clip_start_d = (chomp_q == '0);
          end
        end
        ST_WIN, ST_FAIL: begin
          if (clip_done) begin
            state_d      = ST_READY;
            clip_d       = CLIP_W'(READY_SAMPLES - 1);
            clip_start_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_LOADING;
          clip_d  = '0;
          chomp_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sound_type_d = SOUND_LOADING;
    audio_en_d   = 1'b0;
    busy_d       = 1'b0;
    case (state_d)
      ST_READY: begin
        sound_type_d = SOUND_READY;
        audio_en_d   = 1'b1;
        busy_d       = 1'b1;
      end
      ST_PLAY: begin
        sound_type_d = SOUND_GAME_PLAY;
        audio_en_d   = (chomp_d != '0);
      end
      ST_WIN: begin
        sound_type_d = SOUND_WIN;
        audio_en_d   = 1'b1;
        busy_d       = 1'b1;
      end
      ST_FAIL: begin
        sound_type_d = SOUND_FAIL;
        audio_en_d   = 1'b1;
        busy_d       = 1'b1;
      end
      default: begin
        sound_type_d = SOUND_LOADING;
      end
    endcase
  end

  always_ff @(posedge clk_25MHZ) begin
    if (!rst_n) begin
      state_q      <= ST_LOADING;
      clip_q       <= '0;
      chomp_q      <= '0;
      sound_type_q <= SOUND_LOADING;
      clip_start_q <= 1'b0;
      audio_en_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clip_q       <= clip_d;
      chomp_q      <= chomp_d;
      sound_type_q <= sound_type_d;
      clip_start_q <= clip_start_d;
      audio_en_q   <= audio_en_d;
      busy_q       <= busy_d;
    end
  end

  assign sound_type = sound_type_q;
  assign clk_8KHZ   = strobe;
  assign clip_start = clip_start_q;
  assign audio_en   = audio_en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with DIV=4, READY=3, CHOMP=2, WIN=2, FAIL=2.
module tb_sound_sequencer;
  import sound_sequencer_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   game_loaded;
  logic   pellet_eaten;
  logic   level_won;
  logic   player_died;
  sound_t sound_type;
  logic   clk_8khz;
  logic   clip_start;
  logic   audio_en;
  logic   busy;

  int vectors;
  int miscompares;
  int ph;

  sound_sequencer #(
    .CLK_HZ        (32_000),
    .SAMPLE_HZ     (8_000),
    .READY_SAMPLES (3),
    .CHOMP_SAMPLES (2),
    .WIN_SAMPLES   (2),
    .FAIL_SAMPLES  (2)
  ) dut (
    .clk_25MHZ    (clk),
    .rst_n        (rst_n),
    .game_loaded  (game_loaded),
    .pellet_eaten (pellet_eaten),
    .level_won    (level_won),
    .player_died  (player_died),
    .sound_type   (sound_type),
    .clk_8KHZ     (clk_8khz),
    .clip_start   (clip_start),
    .audio_en     (audio_en),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input sound_t obs, input sound_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; ph counts edges since the last reset edge, strobe expected when ph is a multiple of 4.
  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = rst_n;
    @(posedge clk);
    #1;
    if (!rst_at_edge) ph = 0;
    else ph++;
    chk_b("strobe", clk_8khz, (ph > 0) && (ph % 4 == 0));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk_s({tag, "_sound"}, sound_type, SOUND_LOADING);
    chk_b({tag, "_start"}, clip_start, 1'b0);
    chk_b({tag, "_audio"}, audio_en, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    ph           = 0;
    rst_n        = 1'b0;
    game_loaded  = 1'b0;
    pellet_eaten = 1'b0;
    level_won    = 1'b0;
    player_died  = 1'b0;

    tick();
    chk_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk_reset("loading");
    end

    game_loaded = 1'b1;
    tick();
    chk_s("ready_sound", sound_type, SOUND_READY);
    chk_b("ready_start", clip_start, 1'b1);
    chk_b("ready_busy", busy, 1'b1);
    chk_b("ready_audio", audio_en, 1'b1);
    tick();
    chk_b("ready_start_drop", clip_start, 1'b0);
    tick_n(10);
    chk_s("ready_last", sound_type, SOUND_READY);
    chk_b("ready_last_busy", busy, 1'b1);
    tick();
    chk_s("play_sound", sound_type, SOUND_GAME_PLAY);
    chk_b("play_busy", busy, 1'b0);
    chk_b("play_audio", audio_en, 1'b0);

    pellet_eaten = 1'b1;
    tick();
    pellet_eaten = 1'b0;
    chk_b("chomp1_start", clip_start, 1'b1);
    chk_b("chomp1_audio", audio_en, 1'b1);
    tick_n(6);
    chk_b("chomp1_held", audio_en, 1'b1);
    tick();
    chk_b("chomp1_end", audio_en, 1'b0);

    pellet_eaten = 1'b1;
    tick();
    pellet_eaten = 1'b0;
    chk_b("chomp2_start", clip_start, 1'b1);
    tick_n(3);
    chk_b("chomp2_mid", audio_en, 1'b1);
    pellet_eaten = 1'b1;
    tick();
    pellet_eaten = 1'b0;
    chk_b("retrig_no_start", clip_start, 1'b0);
    chk_b("retrig_audio", audio_en, 1'b1);
    tick_n(6);
    chk_b("retrig_held", audio_en, 1'b1);
    tick();
    chk_b("retrig_end", audio_en, 1'b0);

    pellet_eaten = 1'b1;
    tick();
    pellet_eaten = 1'b0;
    chk_b("chomp3_start", clip_start, 1'b1);
    player_died = 1'b1;
    level_won   = 1'b1;
    tick();
    player_died = 1'b0;
    level_won   = 1'b0;
    chk_s("fail_sound", sound_type, SOUND_FAIL);
    chk_b("fail_busy", busy, 1'b1);
    chk_b("fail_start", clip_start, 1'b1);
    tick_n(2);
    level_won = 1'b1;
    tick();
    level_won = 1'b0;
    chk_s("fail_won_ignored", sound_type, SOUND_FAIL);
    chk_b("fail_won_no_start", clip_start, 1'b0);
    tick_n(2);
    chk_s("fail_last", sound_type, SOUND_FAIL);
    tick();
    chk_s("respawn_sound", sound_type, SOUND_READY);
    chk_b("respawn_start", clip_start, 1'b1);
    chk_b("respawn_busy", busy, 1'b1);

    tick_n(4);
    pellet_eaten = 1'b1;
    tick();
    pellet_eaten = 1'b0;
    chk_b("ready_pellet_no_start", clip_start, 1'b0);
    chk_s("ready_pellet_sound", sound_type, SOUND_READY);
    tick_n(6);
    chk_s("ready2_last", sound_type, SOUND_READY);
    tick();
    chk_s("play2_sound", sound_type, SOUND_GAME_PLAY);
    chk_b("play2_audio", audio_en, 1'b0);

    level_won = 1'b1;
    tick();
    level_won = 1'b0;
    chk_s("win_sound", sound_type, SOUND_WIN);
    chk_b("win_busy", busy, 1'b1);
    chk_b("win_start", clip_start, 1'b1);
    tick_n(3);
    chk_s("win_mid", sound_type, SOUND_WIN);

    rst_n       = 1'b0;
    game_loaded = 1'b0;
    tick();
    chk_reset("midwin_reset");
    chk_b("midwin_strobe", clk_8khz, 1'b0);
    rst_n = 1'b1;
    tick_n(4);
    chk_reset("post_reset");

    game_loaded = 1'b1;
    tick();
    chk_s("reload_sound", sound_type, SOUND_READY);
    chk_b("reload_start", clip_start, 1'b1);
    game_loaded = 1'b0;
    tick();
    chk_reset("unload");
    tick_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
